sram_wr_sched: RTL and testbench

Write scheduler for the shared packet SRAM of the multi-port cache. It arbitrates round-robin among NUM_PORTS input-port FIFOs that each hold a complete packet, and pops one free block address per word from the free-address list. It drives the SRAM write stage's address/valid and the FIFO read-mux select, writes the block link list, and emits one packet descriptor per stored packet. It sits between the per-port input FIFOs and free list upstream and the SRAM write stage, link RAM and descriptor queue downstream.

---
 rtl/sram_wr_sched_pkg.sv | 27 ++
 rtl/sram_wr_sched_if.sv | 43 ++++
 rtl/sram_wr_sched_rr_arbiter.sv | 32 +++
 rtl/sram_wr_sched.sv | 150 +++++++++++++++
 tb/tb_sram_wr_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_wr_sched_pkg.sv
// Shared types and default sizes for the multi-port cache packet SRAM write path.
package mpcache_pkg;

    localparam int MP_NUM_PORTS = 4;
    localparam int MP_ADDR_W    = 12;
    localparam int MP_LEN_W     = 6;
    localparam int MP_SEL_W     = $clog2(MP_NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    // Packet descriptor as queued downstream; widths follow the package defaults.
    typedef struct packed {
        logic [MP_SEL_W-1:0]  port;
        logic [MP_ADDR_W-1:0] head;
        logic [MP_LEN_W-1:0]  len;
    } desc_t;

    // Increment with explicit wrap so non-power-of-2 port counts rotate correctly.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sram_wr_sched_if.sv
// Bundle of request, free-list, SRAM write, link RAM and descriptor signals
// around the write scheduler. master = scheduler side, slave = its environment.
interface sram_wr_sched_if
    import mpcache_pkg::*;
#(
    parameter int NUM_PORTS = MP_NUM_PORTS,
    parameter int ADDR_W    = MP_ADDR_W,
    parameter int LEN_W     = MP_LEN_W
);
    localparam int SEL_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]       i_req;
    logic [NUM_PORTS*LEN_W-1:0] i_req_len;
    logic [NUM_PORTS-1:0]       o_grant;
    logic [SEL_W-1:0]           o_port_sel;
    logic [ADDR_W-1:0]          i_free_addr;
    logic                       i_free_vld;
    logic                       o_free_ren;
    logic [ADDR_W-1:0]          o_sram_addr;
    logic                       o_sram_addr_vld;
    logic                       o_link_wr;
    logic [ADDR_W-1:0]          o_link_addr;
    logic [ADDR_W-1:0]          o_link_next;
    logic                       o_desc_vld;
    logic [SEL_W-1:0]           o_desc_port;
    logic [ADDR_W-1:0]          o_desc_head;
    logic [LEN_W-1:0]           o_desc_len;

    modport master (
        input  i_req, i_req_len, i_free_addr, i_free_vld,
        output o_grant, o_port_sel, o_free_ren, o_sram_addr, o_sram_addr_vld,
        output o_link_wr, o_link_addr, o_link_next,
        output o_desc_vld, o_desc_port, o_desc_head, o_desc_len
    );

    modport slave (
        output i_req, i_req_len, i_free_addr, i_free_vld,
        input  o_grant, o_port_sel, o_free_ren, o_sram_addr, o_sram_addr_vld,
        input  o_link_wr, o_link_addr, o_link_next,
        input  o_desc_vld, o_desc_port, o_desc_head, o_desc_len
    );

endinterface

// File: rtl/sram_wr_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SEL_W-1:0]     idx,
    output logic                 any
);

    int k;

    // Scan ports starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_PORTS) k = k - NUM_PORTS;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/sram_wr_sched.sv
// Packet write scheduler: grants one input port per packet, pops one free
// block per word, chains blocks in the link RAM and emits a descriptor.
//
// state | meaning
// IDLE  | arbitrate; latch owner, length and advance the round-robin pointer
// BURST | one word per cycle while the free list supplies addresses
// DONE  | descriptor pulse; grant released
module sram_wr_sched
    import mpcache_pkg::*;
#(
    parameter int NUM_PORTS = MP_NUM_PORTS,
    parameter int ADDR_W    = MP_ADDR_W,
    parameter int LEN_W     = MP_LEN_W
) (
    input logic             i_clk,
    input logic             i_rst_n,
    sram_wr_sched_if.master bus
);

    localparam int SEL_W = $clog2(NUM_PORTS);

    sched_state_e         state_q, state_d;
    logic [SEL_W-1:0]     rr_ptr_q;
    logic [SEL_W-1:0]     port_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     remaining_q;
    logic [ADDR_W-1:0]    head_q;
    logic [ADDR_W-1:0]    prev_q;
    logic                 first_q;

    logic [NUM_PORTS-1:0] arb_grant;
    logic [SEL_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [LEN_W-1:0]     sel_len;
    logic [LEN_W-1:0]     start_len;
    logic                 pop;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_W     (SEL_W)
    ) u_rr_arbiter (
        .req   (bus.i_req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Length field of the port the arbiter would grant this cycle.
    always_comb begin
        sel_len = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (arb_grant[p]) sel_len = sel_len | bus.i_req_len[p*LEN_W +: LEN_W];
        end
    end

    // A zero-length request still stores one word.
    assign start_len = (sel_len == '0) ? LEN_W'(1) : sel_len;

    // One word per cycle whenever the free list has an address during a burst.
    assign pop = (state_q == BURST) && bus.i_free_vld;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and all outputs; write strobes follow the free list combinationally.
    always_comb begin
        state_d             = state_q;
        bus.o_grant         = '0;
        bus.o_port_sel      = '0;
        bus.o_free_ren      = 1'b0;
        bus.o_sram_addr_vld = 1'b0;
        bus.o_sram_addr     = '0;
        bus.o_link_wr       = 1'b0;
        bus.o_link_addr     = '0;
        bus.o_link_next     = '0;
        bus.o_desc_vld      = 1'b0;
        bus.o_desc_port     = '0;
        bus.o_desc_head     = '0;
        bus.o_desc_len      = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) state_d = BURST;
            end
            BURST: begin
                bus.o_grant    = NUM_PORTS'(1) << port_q;
                bus.o_port_sel = port_q;
                if (pop) begin
                    bus.o_free_ren      = 1'b1;
                    bus.o_sram_addr_vld = 1'b1;
                    bus.o_sram_addr     = bus.i_free_addr;
                    if (!first_q) begin
                        bus.o_link_wr   = 1'b1;
                        bus.o_link_addr = prev_q;
                        bus.o_link_next = bus.i_free_addr;
                    end
                    if (remaining_q == LEN_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                bus.o_desc_vld  = 1'b1;
                bus.o_desc_port = port_q;
                bus.o_desc_head = head_q;
                bus.o_desc_len  = len_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst bookkeeping: owner capture at grant, head/prev/remaining per popped word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q    <= '0;
            port_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            head_q      <= '0;
            prev_q      <= '0;
            first_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        port_q      <= arb_idx;
                        len_q       <= start_len;
                        remaining_q <= start_len;
                        first_q     <= 1'b1;
                        rr_ptr_q    <= SEL_W'(wrap_inc(int'(arb_idx), NUM_PORTS));
                    end
                end
                BURST: begin
                    if (pop) begin
                        if (first_q) begin
                            head_q  <= bus.i_free_addr;
                            first_q <= 1'b0;
                        end
                        prev_q      <= bus.i_free_addr;
                        remaining_q <= remaining_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wr_sched.sv
// Directed bench for the packet SRAM write scheduler.
module tb_sram_wr_sched;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int LW = 6;

    logic i_clk;
    logic i_rst_n;
    int   errors;
    int   checks;

    sram_wr_sched_if #(.NUM_PORTS(NP), .ADDR_W(AW), .LEN_W(LW)) bus ();

    sram_wr_sched #(.NUM_PORTS(NP), .ADDR_W(AW), .LEN_W(LW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; the free-list head moves on when the DUT popped at that edge.
    task automatic tick();
        logic p;
        p = bus.o_free_ren;
        @(negedge i_clk);
        if (p) bus.i_free_addr = bus.i_free_addr + 12'd1;
    endtask

    task automatic do_reset(input logic [AW-1:0] base);
        @(negedge i_clk);
        i_rst_n         = 1'b0;
        bus.i_req       = '0;
        bus.i_req_len   = '0;
        bus.i_free_vld  = 1'b1;
        bus.i_free_addr = base;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst_n         = 1'b0;
        bus.i_req       = 4'b1111;
        bus.i_req_len   = '0;
        bus.i_free_vld  = 1'b1;
        bus.i_free_addr = 12'h0AB;
        #1;
        checks++;
        if (bus.o_grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant: got %b expected 0000", bus.o_grant);
        end
        checks++;
        if ({bus.o_free_ren, bus.o_sram_addr_vld, bus.o_link_wr, bus.o_desc_vld} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000",
                {bus.o_free_ren, bus.o_sram_addr_vld, bus.o_link_wr, bus.o_desc_vld});
        end
        checks++;
        if ({bus.o_sram_addr, bus.o_link_addr, bus.o_link_next, bus.o_port_sel} !== '0) begin
            errors++; $display("FAIL reset_buses: sram_addr %h link %h->%h sel %0d expected all 0",
                bus.o_sram_addr, bus.o_link_addr, bus.o_link_next, bus.o_port_sel);
        end
        checks++;
        if ({bus.o_desc_port, bus.o_desc_head, bus.o_desc_len} !== '0) begin
            errors++; $display("FAIL reset_desc: port %0d head %h len %0d expected all 0",
                bus.o_desc_port, bus.o_desc_head, bus.o_desc_len);
        end
        bus.i_req = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (bus.o_grant !== 4'b0000) begin
            errors++; $display("FAIL reset_idle_grant: got %b expected 0000", bus.o_grant);
        end
    endtask

    task automatic test_single();
        logic [3:0]    eg [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic          ev [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [AW-1:0] ea [5] = '{12'h010, 12'h011, 12'h012, 12'h000, 12'h000};
        logic          el [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [AW-1:0] ela[5] = '{12'h000, 12'h010, 12'h011, 12'h000, 12'h000};
        logic [AW-1:0] eln[5] = '{12'h000, 12'h011, 12'h012, 12'h000, 12'h000};
        logic          ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset(12'h010);
        bus.i_req           = 4'b0100;
        bus.i_req_len[2*LW +: LW] = 6'd3;
        #1;
        checks++;
        if (bus.o_grant !== 4'b0000) begin
            errors++; $display("FAIL single_grant_latency: got %b expected 0000", bus.o_grant);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) bus.i_req = '0;
            #1;
            checks++;
            if (bus.o_grant !== eg[c]) begin
                errors++; $display("FAIL single_grant c%0d: got %b expected %b", c, bus.o_grant, eg[c]);
            end
            checks++;
            if (bus.o_sram_addr_vld !== ev[c] || bus.o_free_ren !== ev[c]) begin
                errors++; $display("FAIL single_vld c%0d: vld %b ren %b expected %b",
                    c, bus.o_sram_addr_vld, bus.o_free_ren, ev[c]);
            end
            if (ev[c]) begin
                checks++;
                if (bus.o_sram_addr !== ea[c] || bus.o_port_sel !== 2'd2) begin
                    errors++; $display("FAIL single_addr c%0d: addr %h sel %0d expected %h sel 2",
                        c, bus.o_sram_addr, bus.o_port_sel, ea[c]);
                end
            end
            checks++;
            if (bus.o_link_wr !== el[c]) begin
                errors++; $display("FAIL single_link_wr c%0d: got %b expected %b", c, bus.o_link_wr, el[c]);
            end
            if (el[c]) begin
                checks++;
                if (bus.o_link_addr !== ela[c] || bus.o_link_next !== eln[c]) begin
                    errors++; $display("FAIL single_link c%0d: got %h->%h expected %h->%h",
                        c, bus.o_link_addr, bus.o_link_next, ela[c], eln[c]);
                end
            end
            checks++;
            if (bus.o_desc_vld !== ed[c]) begin
                errors++; $display("FAIL single_desc_vld c%0d: got %b expected %b", c, bus.o_desc_vld, ed[c]);
            end
            if (ed[c]) begin
                checks++;
                if (bus.o_desc_port !== 2'd2 || bus.o_desc_head !== 12'h010 || bus.o_desc_len !== 6'd3) begin
                    errors++; $display("FAIL single_desc: got {%0d,%h,%0d} expected {2,010,3}",
                        bus.o_desc_port, bus.o_desc_head, bus.o_desc_len);
                end
            end
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_g;
        int         owner;
        do_reset(12'h100);
        bus.i_req     = 4'b1111;
        bus.i_req_len = {6'd1, 6'd1, 6'd1, 6'd1};
        for (int c = 1; c <= 15; c++) begin
            tick();
            #1;
            owner = ((c - 1) / 3) % 4;
            exp_g = (c % 3 == 1) ? (4'b0001 << owner) : 4'b0000;
            checks++;
            if (bus.o_grant !== exp_g) begin
                errors++; $display("FAIL rotate_grant c%0d: got %b expected %b", c, bus.o_grant, exp_g);
            end
            checks++;
            if (bus.o_link_wr !== 1'b0) begin
                errors++; $display("FAIL rotate_no_link c%0d: got %b expected 0", c, bus.o_link_wr);
            end
            if (c % 3 == 2) begin
                checks++;
                if (bus.o_desc_vld !== 1'b1 || bus.o_desc_port !== 2'(owner) || bus.o_desc_len !== 6'd1) begin
                    errors++; $display("FAIL rotate_desc c%0d: vld %b port %0d len %0d expected 1 %0d 1",
                        c, bus.o_desc_vld, bus.o_desc_port, bus.o_desc_len, owner);
                end
            end
        end
        bus.i_req = '0;
    endtask

    task automatic test_stall();
        int pops = 0, stall_cnt = 0, grant_bad = 0, ren_bad = 0, done_c = 0;
        do_reset(12'h200);
        bus.i_req = 4'b0001;
        bus.i_req_len[0 +: LW] = 6'd4;
        for (int c = 1; c <= 30 && done_c == 0; c++) begin
            tick();
            bus.i_req = '0;
            if (pops == 2 && stall_cnt < 5) begin
                bus.i_free_vld = 1'b0;
                stall_cnt++;
            end else begin
                bus.i_free_vld = 1'b1;
            end
            #1;
            if ((bus.o_free_ren || bus.o_sram_addr_vld) && !bus.i_free_vld) ren_bad++;
            if (bus.o_sram_addr_vld) pops++;
            if (bus.o_desc_vld) begin
                done_c = c;
                checks++;
                if (bus.o_desc_len !== 6'd4 || bus.o_desc_head !== 12'h200 || bus.o_desc_port !== 2'd0) begin
                    errors++; $display("FAIL stall_desc: got {%0d,%h,%0d} expected {0,200,4}",
                        bus.o_desc_port, bus.o_desc_head, bus.o_desc_len);
                end
            end else if (bus.o_grant !== 4'b0001) begin
                grant_bad++;
            end
        end
        bus.i_free_vld = 1'b1;
        checks++;
        if (pops !== 4) begin
            errors++; $display("FAIL stall_pops: got %0d expected 4", pops);
        end
        checks++;
        if (grant_bad !== 0) begin
            errors++; $display("FAIL stall_grant_held: %0d cycles without grant, expected 0", grant_bad);
        end
        checks++;
        if (ren_bad !== 0) begin
            errors++; $display("FAIL stall_ren: %0d pops while free list empty, expected 0", ren_bad);
        end
        checks++;
        if (done_c !== 10) begin
            errors++; $display("FAIL stall_timing: descriptor at cycle %0d expected 10", done_c);
        end
    endtask

    task automatic test_mid_change();
        int pops = 0, done_c = 0;
        do_reset(12'h300);
        bus.i_req = 4'b0010;
        bus.i_req_len[1*LW +: LW] = 6'd5;
        for (int c = 1; c <= 20 && done_c == 0; c++) begin
            tick();
            if (pops == 1) begin
                bus.i_req = '0;
                bus.i_req_len[1*LW +: LW] = 6'd2;
            end
            #1;
            if (bus.o_sram_addr_vld) pops++;
            if (bus.o_desc_vld) begin
                done_c = c;
                checks++;
                if (bus.o_desc_len !== 6'd5 || bus.o_desc_port !== 2'd1 || bus.o_desc_head !== 12'h300) begin
                    errors++; $display("FAIL mid_desc: got {%0d,%h,%0d} expected {1,300,5}",
                        bus.o_desc_port, bus.o_desc_head, bus.o_desc_len);
                end
            end
        end
        checks++;
        if (pops !== 5) begin
            errors++; $display("FAIL mid_pops: got %0d expected 5", pops);
        end
        checks++;
        if (done_c !== 6) begin
            errors++; $display("FAIL mid_timing: descriptor at cycle %0d expected 6", done_c);
        end
    endtask

    task automatic test_len_zero();
        int pops = 0, links = 0, done_c = 0;
        do_reset(12'h400);
        bus.i_req = 4'b1000;
        for (int c = 1; c <= 10 && done_c == 0; c++) begin
            tick();
            bus.i_req = '0;
            #1;
            if (bus.o_sram_addr_vld) pops++;
            if (bus.o_link_wr) links++;
            if (bus.o_desc_vld) begin
                done_c = c;
                checks++;
                if (bus.o_desc_len !== 6'd1 || bus.o_desc_port !== 2'd3 || bus.o_desc_head !== 12'h400) begin
                    errors++; $display("FAIL len0_desc: got {%0d,%h,%0d} expected {3,400,1}",
                        bus.o_desc_port, bus.o_desc_head, bus.o_desc_len);
                end
            end
        end
        checks++;
        if (pops !== 1 || links !== 0 || done_c !== 2) begin
            errors++; $display("FAIL len0_count: pops %0d links %0d desc cycle %0d expected 1 0 2",
                pops, links, done_c);
        end
    endtask

    task automatic test_reset_mid();
        int descs = 0;
        do_reset(12'h500);
        bus.i_req = 4'b0100;
        bus.i_req_len[2*LW +: LW] = 6'd8;
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.i_req = '0;
            #1;
        end
        checks++;
        if (bus.o_sram_addr_vld !== 1'b1 || bus.o_grant !== 4'b0100) begin
            errors++; $display("FAIL rstmid_pre: vld %b grant %b expected 1 0100",
                bus.o_sram_addr_vld, bus.o_grant);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_grant, bus.o_port_sel, bus.o_free_ren, bus.o_sram_addr_vld, bus.o_link_wr,
             bus.o_desc_vld} !== '0) begin
            errors++; $display("FAIL rstmid_ctrl: grant %b sel %0d ren %b vld %b link %b desc %b expected 0",
                bus.o_grant, bus.o_port_sel, bus.o_free_ren, bus.o_sram_addr_vld, bus.o_link_wr,
                bus.o_desc_vld);
        end
        checks++;
        if ({bus.o_sram_addr, bus.o_link_addr, bus.o_link_next, bus.o_desc_port, bus.o_desc_head,
             bus.o_desc_len} !== '0) begin
            errors++; $display("FAIL rstmid_data: addr %h link %h->%h desc {%0d,%h,%0d} expected 0",
                bus.o_sram_addr, bus.o_link_addr, bus.o_link_next, bus.o_desc_port,
                bus.o_desc_head, bus.o_desc_len);
        end
        @(negedge i_clk);
        if (bus.o_desc_vld) descs++;
        i_rst_n = 1'b1;
        bus.i_req = 4'b1001;
        bus.i_req_len[0 +: LW]    = 6'd2;
        bus.i_req_len[3*LW +: LW] = 6'd2;
        #1;
        if (bus.o_desc_vld) descs++;
        tick();
        bus.i_req = '0;
        #1;
        checks++;
        if (bus.o_grant !== 4'b0001) begin
            errors++; $display("FAIL rstmid_ptr: got grant %b expected 0001", bus.o_grant);
        end
        checks++;
        if (descs !== 0) begin
            errors++; $display("FAIL rstmid_no_desc: got %0d descriptors expected 0", descs);
        end
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        i_rst_n         = 1'b0;
        bus.i_req       = '0;
        bus.i_req_len   = '0;
        bus.i_free_vld  = 1'b0;
        bus.i_free_addr = '0;
        test_reset();
        test_single();
        test_rotate();
        test_stall();
        test_mid_change();
        test_len_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
